// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the digit-serial adder.
// Optional build macro SERIAL_ADDER_SUB_EN (see serial_adder.sv) adds subtraction.
package serial_adder_pkg;

  // Controller states: waiting for operands, stepping digits, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide slices in a WIDTH-bit operand.
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
// The master side supplies operands and consumes results; the slave is the adder.
// With SERIAL_ADDER_SUB_EN defined, the bundle also carries the Sub select.
interface serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

`ifdef SERIAL_ADDER_SUB_EN
  logic             Sub;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout
  );
`else
  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout
  );
`endif

endinterface

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple-carry adder made of full-adder cells.
// This is the only arithmetic in serial_adder; it is reused for every digit.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  // c[i] is the carry into bit i; c[DIGIT] leaves the digit.
  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    assign s[gi]     = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi + 1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial WIDTH-bit adder, DIGIT bits per clock, LSD first.
// Operands are captured on accept, summed over NDIG cycles through a single
// digit_adder with a registered carry, then held until the consumer takes them.
// Build macro SERIAL_ADDER_SUB_EN: adds a Sub select (A - B when Sub=1, Cin=0).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Reject configurations that would leave a partial top digit.
  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             cy_q,    cy_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;

  // Digit currently being added and its result.
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] s_dig;
  logic             co_dig;
  logic             last_dig;
  logic             cy_init;
  int               base;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q, sub_d;
`endif

  // Select the active operand digits; subtraction inverts B so that the
  // same adder computes A + ~B + 1.
  always_comb begin
    base     = int'(cnt_q) * DIGIT;
    a_dig    = a_q[base +: DIGIT];
`ifdef SERIAL_ADDER_SUB_EN
    b_dig    = b_q[base +: DIGIT] ^ {DIGIT{sub_q}};
    cy_init  = bus.Cin ^ bus.Sub;
`else
    b_dig    = b_q[base +: DIGIT];
    cy_init  = bus.Cin;
`endif
    last_dig = (cnt_q == CW'(NDIG - 1));
  end

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .a (a_dig),
    .b (b_dig),
    .ci(cy_q),
    .s (s_dig),
    .co(co_dig)
  );

  // Next-state logic: capture in IDLE, one digit per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d   = sub_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          cy_d    = cy_init;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_d   = bus.Sub;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        // Only the active digit of Sum changes; the rest keep old contents.
        sum_d[base +: DIGIT] = s_dig;
        cy_d                 = co_dig;
        if (last_dig) begin
          cout_d  = co_dig;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // in_ready is held low for the whole time reset is asserted.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed, table-driven bench for serial_adder.
// Covers WIDTH=16/DIGIT=4 plus WIDTH=8 with DIGIT=8 and DIGIT=1.
// Build with SERIAL_ADDER_SUB_EN to add the subtraction vectors.
module tb_serial_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(16)) if16 ();
  serial_adder_if #(.WIDTH(8))  if8a ();
  serial_adder_if #(.WIDTH(8))  if8b ();

  serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));
  serial_adder #(.WIDTH(8),  .DIGIT(8)) u8a (.clk(clk), .rst(rst), .bus(if8a.slave));
  serial_adder #(.WIDTH(8),  .DIGIT(1)) u8b (.clk(clk), .rst(rst), .bus(if8b.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the 16-bit adder with out_ready held high.
  task automatic run_op16(input vec_t v);
    int lat;
    if16.A         = v.a;
    if16.B         = v.b;
    if16.Cin       = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
    if16.Sub       = v.sub;
`endif
    if16.out_ready = 1'b1;
    if16.in_valid  = 1'b1;
    check("in_ready_idle", 32'(if16.in_ready), 32'd1);
    step();
    if16.in_valid = 1'b0;
    lat = 0;
    while (!if16.out_valid && lat < 50) begin
      step();
      lat++;
    end
    check("latency16", lat, 32'd4);
    check("sum16", 32'(if16.Sum), 32'(v.exp_sum));
    check("cout16", 32'(if16.Cout), 32'(v.exp_cout));
    $display("op16 a=%04h b=%04h cin=%0d sub=%0d -> sum=%04h cout=%0d lat=%0d",
             v.a, v.b, v.cin, v.sub, if16.Sum, if16.Cout, lat);
    step();
    check("out_valid_drop", 32'(if16.out_valid), 32'd0);
    check("in_ready_back", 32'(if16.in_ready), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    int lat_a, lat_b, c;
    logic [7:0] sum_a, sum_b;
    logic       cout_a, cout_b;

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0});
    vecs.push_back('{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
`endif

    if16.in_valid = 1'b0; if16.out_ready = 1'b1; if16.A = '0; if16.B = '0; if16.Cin = 1'b0;
    if8a.in_valid = 1'b0; if8a.out_ready = 1'b1; if8a.A = '0; if8a.B = '0; if8a.Cin = 1'b0;
    if8b.in_valid = 1'b0; if8b.out_ready = 1'b1; if8b.A = '0; if8b.B = '0; if8b.Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    if16.Sub = 1'b0; if8a.Sub = 1'b0; if8b.Sub = 1'b0;
`endif

    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    check("rst_out_valid", 32'(if16.out_valid), 32'd0);
    check("rst_in_ready", 32'(if16.in_ready), 32'd0);
    check("rst_sum", 32'(if16.Sum), 32'd0);
    check("rst_cout", 32'(if16.Cout), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(if16.in_ready), 32'd1);

    // Table-driven vectors.
    foreach (vecs[i]) run_op16(vecs[i]);

    // Backpressure: hold result while in_valid toggles operands.
    if16.out_ready = 1'b0;
    if16.A = 16'h1111; if16.B = 16'h2222; if16.Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    if16.Sub = 1'b0;
`endif
    if16.in_valid = 1'b1;
    step();
    if16.in_valid = 1'b0;
    c = 0;
    while (!if16.out_valid && c < 50) begin
      step();
      c++;
    end
    check("bp_latency", c, 32'd4);
    for (int k = 0; k < 5; k++) begin
      if16.in_valid = 1'b1;
      if16.A = 16'h0F0F + 16'(k);
      if16.B = 16'h7000 - 16'(k);
      step();
      check("bp_sum_hold", 32'(if16.Sum), 32'h3333);
      check("bp_cout_hold", 32'(if16.Cout), 32'd0);
      check("bp_in_ready", 32'(if16.in_ready), 32'd0);
      check("bp_out_valid", 32'(if16.out_valid), 32'd1);
    end
    $display("op16 backpressure a=1111 b=2222 -> sum=%04h held for 5 cycles", if16.Sum);
    if16.A = 16'h0100; if16.B = 16'h0200; if16.in_valid = 1'b1;
    if16.out_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(if16.out_valid), 32'd0);
    check("bp_release_ready", 32'(if16.in_ready), 32'd1);
    step();
    if16.in_valid = 1'b0;
    c = 0;
    while (!if16.out_valid && c < 50) begin
      step();
      c++;
    end
    check("bp_next_latency", c, 32'd4);
    check("bp_next_sum", 32'(if16.Sum), 32'h0300);
    $display("op16 after backpressure a=0100 b=0200 -> sum=%04h", if16.Sum);
    step();

    // Reset in the middle of RUN.
    if16.A = 16'h1234; if16.B = 16'h1111; if16.Cin = 1'b0; if16.in_valid = 1'b1;
    step();
    if16.in_valid = 1'b0;
    step();
    step();
    check("midrun_sum_partial", 32'(if16.Sum[7:0]), 32'h45);
    rst = 1'b1;
    step();
    check("midrun_rst_valid", 32'(if16.out_valid), 32'd0);
    check("midrun_rst_sum", 32'(if16.Sum), 32'd0);
    check("midrun_rst_cout", 32'(if16.Cout), 32'd0);
    rst = 1'b0;
    #1;
    check("midrun_idle", 32'(if16.in_ready), 32'd1);
    $display("op16 reset mid-run -> sum=%04h out_valid=%0d", if16.Sum, if16.out_valid);
    run_op16('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0});

    // WIDTH=8 with DIGIT=8 and DIGIT=1 in parallel.
    lat_a = 99; lat_b = 99;
    sum_a = 8'hxx; sum_b = 8'hxx; cout_a = 1'bx; cout_b = 1'bx;
    if8a.A = 8'h80; if8a.B = 8'h80; if8a.in_valid = 1'b1;
    if8b.A = 8'h80; if8b.B = 8'h80; if8b.in_valid = 1'b1;
    step();
    if8a.in_valid = 1'b0;
    if8b.in_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (lat_a == 99 && if8a.out_valid) begin
        lat_a = k; sum_a = if8a.Sum; cout_a = if8a.Cout;
      end
      if (lat_b == 99 && if8b.out_valid) begin
        lat_b = k; sum_b = if8b.Sum; cout_b = if8b.Cout;
      end
      if (lat_a != 99 && lat_b != 99) break;
      step();
    end
    // The loop checks before stepping, so an edge count of k shows up as k+1.
    check("w8d8_latency", lat_a - 1, 32'd1);
    check("w8d8_sum", 32'(sum_a), 32'h00);
    check("w8d8_cout", 32'(cout_a), 32'd1);
    check("w8d1_latency", lat_b - 1, 32'd8);
    check("w8d1_sum", 32'(sum_b), 32'h00);
    check("w8d1_cout", 32'(cout_b), 32'd1);
    $display("op8 d8 a=80 b=80 -> sum=%02h cout=%0d lat=%0d", sum_a, cout_a, lat_a - 1);
    $display("op8 d1 a=80 b=80 -> sum=%02h cout=%0d lat=%0d", sum_b, cout_b, lat_b - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
